led_grid_scanner: RTL and testbench

Multiplexed LED-grid driver for the Frogger board; consumes the 40-bit game grid produced by the processor (`grid_values` / `grid_ready`) and drives a 5-column × 8-row LED matrix one column at a time. It sits directly downstream of the processor in `skeleton`, filling the LED display slot, and feeds the `col1`–`col5` pins plus 8 row pins. Frames are double-buffered so a grid update never tears mid-scan.

---
 rtl/led_grid_scanner_if.sv | 42 ++++
 rtl/led_grid_scanner.sv | 133 +++++++++++++
 tb/tb_led_grid_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_grid_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_grid_scanner_if
//  Description : Bundle between the grid producer and the LED-grid scanner.
//                Carries the 40-bit frame with its ready strobe, the
//                ack/frame-done pulses, and the column/row drive lines.
//                  grid_values [39:0]  new frame, bit c*8+r = column c, row r
//                  grid_ready          single-cycle strobe, grid_values valid
//                  grid_ack            pulse when a frame is promoted
//                  frame_done          pulse at the end of each 5-column scan
//                  col [4:0]           one-hot column enable
//                  row [7:0]           row data for the enabled column
//                master : frame producer side; slave : scanner side.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_grid_scanner_if;
    logic [39:0] grid_values;
    logic        grid_ready;
    logic        grid_ack;
    logic        frame_done;
    logic [4:0]  col;
    logic [7:0]  row;

    modport master (
        output grid_values,
        output grid_ready,
        input  grid_ack,
        input  frame_done,
        input  col,
        input  row
    );

    modport slave (
        input  grid_values,
        input  grid_ready,
        output grid_ack,
        output frame_done,
        output col,
        output row
    );
endinterface
`default_nettype wire

// File: rtl/led_grid_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : led_grid_scanner
//  Description : Multiplexed 5-column x 8-row LED matrix driver. Each column
//                is preceded by BLANK dark cycles (ghost suppression) and then
//                lit for DWELL cycles. Incoming frames land in a shadow
//                buffer and are promoted to the displayed buffer only at the
//                end of a complete scan, so an image never tears.
//  Ports       : clock   - system clock, rising edge
//                resetn  - asynchronous active-low reset
//                bus     - led_grid_scanner_if.slave (frame in, LED drive out)
//  Revision    : 1.0  initial release
// ============================================================================
module led_grid_scanner #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 500
) (
    input  wire                   clock,
    input  wire                   resetn,
    led_grid_scanner_if.slave     bus
);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    localparam logic [31:0] c_DWELL_RELOAD = 32'(DWELL - 1);
    localparam logic [31:0] c_BLANK_RELOAD = 32'(BLANK - 1);
    localparam logic [2:0]  c_LAST_COL     = 3'd4;

    logic [0:0]  state_q,   state_d;
    logic [31:0] cnt_q,     cnt_d;
    logic [2:0]  cidx_q,    cidx_d;
    logic [39:0] front_q,   front_d;
    logic [39:0] shadow_q,  shadow_d;
    logic        pending_q, pending_d;
    logic [4:0]  col_q,     col_d;
    logic [7:0]  row_q,     row_d;
    logic        ack_q,     ack_d;
    logic        done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 32'd1;
        cidx_d    = cidx_q;
        front_d   = front_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;

        // Latest strobe always wins the shadow buffer.
        if (bus.grid_ready) begin
            shadow_d  = bus.grid_values;
            pending_d = 1'b1;
        end

        if (cnt_q == 32'd0) begin
            if (state_q == S_BLANK) begin
                state_d = S_DRIVE;
                cnt_d   = c_DWELL_RELOAD;
            end else begin
                state_d = S_BLANK;
                cnt_d   = c_BLANK_RELOAD;
                if (cidx_q == c_LAST_COL) begin
                    // Frame boundary: a strobe on this very cycle bypasses
                    // the shadow so it is not left stranded for a frame.
                    cidx_d = 3'd0;
                    done_d = 1'b1;
                    if (bus.grid_ready) begin
                        front_d   = bus.grid_values;
                        pending_d = 1'b0;
                        ack_d     = 1'b1;
                    end else if (pending_q) begin
                        front_d   = shadow_q;
                        pending_d = 1'b0;
                        ack_d     = 1'b1;
                    end
                end else begin
                    cidx_d = cidx_q + 3'd1;
                end
            end
        end

        // Outputs are derived from next state so the registered drive lines
        // line up with the state they describe.
        col_d = 5'b00000;
        row_d = 8'h00;
        if (state_d == S_DRIVE) begin
            col_d = 5'b00001 << cidx_d;
            case (cidx_d)
                3'd0:    row_d = front_d[7:0];
                3'd1:    row_d = front_d[15:8];
                3'd2:    row_d = front_d[23:16];
                3'd3:    row_d = front_d[31:24];
                3'd4:    row_d = front_d[39:32];
                default: row_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_BLANK;
            cnt_q     <= c_BLANK_RELOAD;
            cidx_q    <= 3'd0;
            front_q   <= 40'd0;
            shadow_q  <= 40'd0;
            pending_q <= 1'b0;
            col_q     <= 5'b00000;
            row_q     <= 8'h00;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cidx_q    <= cidx_d;
            front_q   <= front_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.grid_ack   = ack_q;
    assign bus.frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_grid_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_grid_scanner
//  Description : Self-checking bench for led_grid_scanner with DWELL=4,
//                BLANK=2 (6-cycle columns, 30-cycle frames). A position-based
//                reference model feeds a scoreboard every cycle; a vector
//                table covers single loads, and hand sequences cover
//                overwrite, boundary bypass, mid-scan reset and tearing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_grid_scanner;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int PER   = DWELL + BLANK;
    localparam int FRAME = 5 * PER;

    typedef struct packed {
        logic [4:0] col;
        logic [7:0] row;
        logic       ack;
        logic       done;
    } exp_t;

    typedef struct {
        int               scol;
        logic [39:0]      data;
        logic [4:0][7:0]  rows;
    } vec_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    led_grid_scanner_if bus ();

    led_grid_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int acks  = 0;

    // Reference model: output state of the current cycle.
    int          pos;
    logic [39:0] mfront, mshadow;
    logic        mpend, mack, mdone;
    logic [7:0]  cap [5];
    exp_t        sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        pos = 0; mfront = '0; mshadow = '0; mpend = 1'b0; mack = 1'b0; mdone = 1'b0;
    endtask

    // One clock cycle with the given strobe; called at posedge+1.
    task automatic step(input logic rdy, input logic [39:0] val);
        exp_t e;
        exp_t got;
        int   c;
        int   ph;
        logic was_pend;
        bus.grid_ready  = rdy;
        bus.grid_values = val;
        c  = pos / PER;
        ph = pos % PER;
        e.col  = (ph >= BLANK) ? 5'(1 << c) : 5'b0;
        e.row  = (ph >= BLANK) ? mfront[c*8 +: 8] : 8'h00;
        e.ack  = mack;
        e.done = mdone;
        sb.push_back(e);
        got = sb.pop_front();
        check("scan", 64'({bus.col, bus.row, bus.grid_ack, bus.frame_done}), 64'(got));
        if (bus.grid_ack === 1'b1) acks++;
        if (ph == BLANK) cap[c] = bus.row;
        // advance model
        was_pend = mpend;
        mack  = 1'b0;
        mdone = 1'b0;
        if (rdy) begin mshadow = val; mpend = 1'b1; end
        if (pos == FRAME - 1) begin
            mdone = 1'b1;
            if (rdy) begin mfront = val; mpend = 1'b0; mack = 1'b1; end
            else if (was_pend) begin mfront = mshadow; mpend = 1'b0; mack = 1'b1; end
        end
        pos = (pos + 1) % FRAME;
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int p);
        while (pos != p) step(1'b0, 40'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 40'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [3];
        int   a0;
        int   a1;
        logic [39:0] last;
        logic [39:0] prev;
        logic [39:0] d;

        tbl[0] = '{2, 40'h0F_A5_3C_81_FF, {8'h0F, 8'hA5, 8'h3C, 8'h81, 8'hFF}};
        tbl[1] = '{0, 40'h01_23_45_67_89, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}};
        tbl[2] = '{4, 40'hAA_55_AA_55_AA, {8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA}};

        bus.grid_ready  = 1'b0;
        bus.grid_values = '0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_col", 64'(bus.col), 64'd0);
        check("reset_ack", 64'(bus.grid_ack), 64'd0);
        resetn = 1'b1;

        // Reset/idle: two blank frames, no ack.
        a0 = acks;
        run(2 * FRAME);
        check("idle_acks", 64'(acks - a0), 64'd0);

        // Table-driven single loads.
        for (int i = 0; i < 3; i++) begin
            goto(tbl[i].scol * PER + BLANK + 1);
            step(1'b1, tbl[i].data);
            goto(0);
            check($sformatf("load%0d_ack", i),  64'(bus.grid_ack),   64'd1);
            check($sformatf("load%0d_done", i), 64'(bus.frame_done), 64'd1);
            run(FRAME);
            for (int c = 0; c < 5; c++)
                check($sformatf("load%0d_row%0d", i, c), 64'(cap[c]), 64'(tbl[i].rows[c]));
        end

        // Overwrite within one frame: one ack, latest frame shown.
        a0 = acks;
        goto(8);
        step(1'b1, 40'h11_11_11_11_11);
        goto(20);
        step(1'b1, 40'h22_22_22_22_22);
        goto(0);
        run(FRAME);
        check("ovw_acks", 64'(acks - a0), 64'd1);
        for (int c = 0; c < 5; c++)
            check($sformatf("ovw_row%0d", c), 64'(cap[c]), 64'h22);

        // Boundary bypass with an older frame pending.
        goto(10);
        step(1'b1, 40'h33_33_33_33_33);
        goto(FRAME - 1);
        step(1'b1, 40'h00_00_00_00_FF);
        check("byp_ack", 64'(bus.grid_ack), 64'd1);
        run(FRAME);
        check("byp_row0", 64'(cap[0]), 64'hFF);
        for (int c = 1; c < 5; c++)
            check($sformatf("byp_row%0d", c), 64'(cap[c]), 64'h00);
        a1 = acks;
        run(FRAME);
        check("byp_no_second_ack", 64'(acks - a1), 64'd0);

        // Mid-scan reset with a frame pending.
        goto(5);
        step(1'b1, 40'h55_55_55_55_55);
        goto(3 * PER + BLANK + 1);
        check("pre_rst_col", 64'(bus.col), 64'b01000);
        resetn = 1'b0;
        #1;
        check("async_rst_col", 64'(bus.col), 64'd0);
        check("async_rst_row", 64'(bus.row), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
        a0 = acks;
        run(2 * FRAME);
        check("rst_no_ack", 64'(acks - a0), 64'd0);

        // Tear check: new frame strobed in every column for three frames.
        goto(0);
        last = '0;
        prev = '0;
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                if (f >= 1 && (p % PER) == BLANK)
                    check($sformatf("tear_f%0d_c%0d", f, p / PER), 64'(bus.row), 64'(prev[(p / PER) * 8 +: 8]));
                if (f < 3 && (p % PER) == BLANK + 1) begin
                    d = {8'($urandom), $urandom};
                    last = d;
                    step(1'b1, d);
                end else begin
                    step(1'b0, 40'd0);
                end
            end
            prev = last;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
